// File: rtl/seg_pkg.sv
// Shared constants, frame-state encoding and BCD-to-binary helper for the
// seven-segment scan decoder.
package seg_pkg;

   localparam logic [7:0] SEG_D0 = 8'b1111_1100;
   localparam logic [7:0] SEG_D1 = 8'b0110_0000;
   localparam logic [7:0] SEG_D2 = 8'b1101_1010;
   localparam logic [7:0] SEG_D3 = 8'b1111_0010;
   localparam logic [7:0] SEG_D4 = 8'b0110_0110;
   localparam logic [7:0] SEG_D5 = 8'b1011_0110;
   localparam logic [7:0] SEG_D6 = 8'b1011_1110;
   localparam logic [7:0] SEG_D7 = 8'b1110_0000;
   localparam logic [7:0] SEG_D8 = 8'b1111_1110;
   localparam logic [7:0] SEG_D9 = 8'b1111_0110;

   localparam logic [1:0] SEL_TENS = 2'b10;
   localparam logic [1:0] SEL_ONES = 2'b01;

   localparam logic [3:0] BCD_ERR = 4'hF;

   typedef enum logic [1:0] {
      IDLE,
      HAVE_TENS,
      HAVE_ONES
   } frame_state_e;

   // ten*10 + one using shifts; both digits are at most 9, so 7 bits suffice.
   function automatic logic [6:0] bcd_to_bin(input logic [3:0] t, input logic [3:0] o);
      return ({3'b000, t} << 3) + ({3'b000, t} << 1) + {3'b000, o};
   endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational seven-segment pattern to BCD digit lookup; dp is ignored and
// unrecognised patterns return BCD_ERR.
module seg7_to_bcd
   import seg_pkg::*;
(
   input  logic [7:0] i_seg,
   output logic [3:0] o_bcd
);

   logic [7:0] w_seg;

   assign w_seg = {i_seg[7:1], 1'b0};

   // NOTE: o_bcd gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      o_bcd = BCD_ERR;
      case (w_seg)
         SEG_D0:  o_bcd = 4'd0;
         SEG_D1:  o_bcd = 4'd1;
         SEG_D2:  o_bcd = 4'd2;
         SEG_D3:  o_bcd = 4'd3;
         SEG_D4:  o_bcd = 4'd4;
         SEG_D5:  o_bcd = 4'd5;
         SEG_D6:  o_bcd = 4'd6;
         SEG_D7:  o_bcd = 4'd7;
         SEG_D8:  o_bcd = 4'd8;
         SEG_D9:  o_bcd = 4'd9;
         default: o_bcd = BCD_ERR;
      endcase
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// Snoops a two-digit multiplexed seven-segment scan bus and recovers the
// displayed number once enough consecutive identical frames agree.
module seg_scan_decoder
   import seg_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4,
   parameter int STABLE_FRAMES = 2,
   parameter int TIMEOUT       = 250000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] digit_con,
   input  logic [7:0] digit_seg,
   output logic [3:0] ten,
   output logic [3:0] one,
   output logic [6:0] value,
   output logic       valid,
   output logic       update,
   output logic       err
);

   localparam int SW = $clog2(SETTLE_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYCLES);
   localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT);
   localparam logic [3:0]    STABLE_MAX  = 4'(STABLE_FRAMES);

   logic [9:0]    r_bus_s1, r_bus_s2;
   logic [SW-1:0] r_settle;
   logic [TW-1:0] r_idle;
   frame_state_e  r_state, w_state_nxt;
   logic [3:0]    r_pend_ten, r_pend_one, r_prev_ten, r_prev_one, r_match;
   logic          r_pend_bad;

   logic [1:0] w_con;
   logic [7:0] w_seg;
   logic [3:0] w_bcd, w_frame_ten, w_frame_one, w_match_nxt;
   logic       w_change, w_sel_ok, w_is_tens, w_capture, w_timeout, w_bcd_err;
   logic       w_frame_done, w_frame_bad, w_same_prev, w_commit;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bus_s1 <= '0;
         r_bus_s2 <= '0;
      end else begin
         r_bus_s1 <= {digit_con, digit_seg};
         r_bus_s2 <= r_bus_s1;
      end
   end

   // A difference between the stages means s2 changes on this edge, restarting the settle count.
   assign w_change  = (r_bus_s1 != r_bus_s2);
   assign w_con     = r_bus_s2[9:8];
   assign w_seg     = r_bus_s2[7:0];
   assign w_is_tens = (w_con == SEL_TENS);
   assign w_sel_ok  = w_is_tens || (w_con == SEL_ONES);
   assign w_capture = !w_change && w_sel_ok && (r_settle == SETTLE_MAX - SW'(1));
   assign w_timeout = !w_capture && (r_idle == TIMEOUT_MAX - TW'(1));

   seg7_to_bcd u_dec (
      .i_seg (w_seg),
      .o_bcd (w_bcd)
   );

   assign w_bcd_err   = (w_bcd == BCD_ERR);
   assign w_frame_ten = w_is_tens ? w_bcd : r_pend_ten;
   assign w_frame_one = w_is_tens ? r_pend_one : w_bcd;
   assign w_frame_bad = r_pend_bad || w_bcd_err;
   assign w_same_prev = ({w_frame_ten, w_frame_one} == {r_prev_ten, r_prev_one});

   always_comb begin
      w_state_nxt  = r_state;
      w_frame_done = 1'b0;
      if (w_capture) begin
         case (r_state)
            IDLE:      w_state_nxt = w_is_tens ? HAVE_TENS : HAVE_ONES;
            HAVE_TENS: if (!w_is_tens) begin
                          w_frame_done = 1'b1;
                          w_state_nxt  = IDLE;
                       end
            HAVE_ONES: if (w_is_tens) begin
                          w_frame_done = 1'b1;
                          w_state_nxt  = IDLE;
                       end
            default:   w_state_nxt = IDLE;
         endcase
      end else if (w_timeout) begin
         w_state_nxt = IDLE;
      end
   end

   always_comb begin
      w_match_nxt = 4'd1;
      if (w_frame_bad)
         w_match_nxt = '0;
      else if (w_same_prev)
         w_match_nxt = (r_match == STABLE_MAX) ? r_match : r_match + 4'd1;
   end

   assign w_commit = w_frame_done && !w_frame_bad && (w_match_nxt == STABLE_MAX) &&
                     (!valid || ({w_frame_ten, w_frame_one} != {ten, one}));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_settle   <= '0;
         r_idle     <= '0;
         r_state    <= IDLE;
         r_pend_ten <= '0;
         r_pend_one <= '0;
         r_pend_bad <= 1'b0;
         r_prev_ten <= '0;
         r_prev_one <= '0;
         r_match    <= '0;
      end else begin
         r_state <= w_state_nxt;

         if (w_change)
            r_settle <= '0;
         else if (r_settle != SETTLE_MAX)
            r_settle <= r_settle + SW'(1);

         if (w_capture)
            r_idle <= '0;
         else if (r_idle != TIMEOUT_MAX)
            r_idle <= r_idle + TW'(1);

         if (w_capture) begin
            if (w_is_tens) r_pend_ten <= w_bcd;
            else           r_pend_one <= w_bcd;
            r_pend_bad <= (r_state == IDLE) ? w_bcd_err : (r_pend_bad || w_bcd_err);
         end

         if (w_frame_done) begin
            r_match <= w_match_nxt;
            if (!w_frame_bad) begin
               r_prev_ten <= w_frame_ten;
               r_prev_one <= w_frame_one;
            end
         end else if (w_timeout) begin
            r_match <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ten    <= '0;
         one    <= '0;
         value  <= '0;
         valid  <= 1'b0;
         update <= 1'b0;
         err    <= 1'b0;
      end else begin
         update <= w_commit;
         err    <= w_capture && w_bcd_err;
         if (w_commit) begin
            ten   <= w_frame_ten;
            one   <= w_frame_one;
            value <= bcd_to_bin(w_frame_ten, w_frame_one);
            valid <= 1'b1;
         end else if (w_timeout) begin
            valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Recovers the number shown on the team's two-digit multiplexed seven-segment display by snooping the scan bus (digit select plus segment lines), the receiving end of the countdown display driver. Each scanned digit is sampled after it settles, the segment pattern is decoded to BCD, and the tens/ones pair is converted to binary. A value is committed only after identical consecutive frames. The block is used in self-check and loop-back test builds, and as the input stage of a display-monitor board.

## Interface
- SETTLE_CYCLES, 4: cycles that digit_con and digit_seg must hold unchanged, after synchronization, before a digit is captured.
- STABLE_FRAMES, 2: number of consecutive identical, error-free frames needed to commit a value (1..15).
- TIMEOUT, 250000: number of cycles with no digit capture before valid drops.
- clk  in  1  system clock; the single clock of the block.
- rst_n  in  1  asynchronous active-low reset.
- digit_con  in  2  digit select. 2'b10 selects tens, 2'b01 selects ones; 00 and 11 mean blanked.
- digit_seg  in  8  segments, active high. bit7 = a, bit6 = b, through bit1 = g; bit0 = dp.
- ten  out  4  committed tens BCD digit.
- one  out  4  committed ones BCD digit.
- value  out  7  committed binary value, equal to ten*10+one (0..99).
- valid  out  1  a committed value exists and the scan is alive.
- update  out  1  one-cycle pulse when the committed value changes, or on the first commit after valid was 0.
- err  out  1  one-cycle pulse when a captured segment pattern does not decode.

## Operation
- Input synchronization: digit_con and digit_seg pass through a 2-flop synchronizer. All logic below uses the synchronized copies.
- Settle counter:
  - Cleared on any change in {con, seg}.
  - Counts up while {con, seg} holds, saturating at SETTLE_CYCLES.
  - Capture fires exactly once per hold, on the cycle the count reaches SETTLE_CYCLES, and only if con is 10 or 01. Blanked codes never capture.
- Decode:
  - dp is masked before lookup.
  - Patterns 11111100, 01100000, 11011010, 11110010, 01100110, 10110110, 10111110, 11100000, 11111110, 11110110 (with dp cleared) map to digits 0..9.
  - Any other pattern decodes as 4'hF.
  - A capture that decodes as 4'hF raises err and marks the current frame bad.
- Frame state machine:
  - States: IDLE, HAVE_TENS, HAVE_ONES.
  - A frame completes when both digits have been captured, in either order.
  - Recapturing the digit already held overwrites it and does not complete the frame.
  - On completion, the FSM returns to IDLE and the pending pair is evaluated.
- Stability:
  - A bad frame clears the match counter.
  - A good frame equal to the previous good frame increments the match counter, saturating at STABLE_FRAMES.
  - A good frame that differs from the previous good frame sets the counter to 1.
  - When the counter reaches STABLE_FRAMES and the pair differs from ten/one, or valid is 0: commit, set valid=1, and pulse update.
  - A stable frame equal to the committed value changes nothing.
- Arithmetic: value = (ten<<3) + (ten<<1) + one, computed in 7 bits. No overflow is possible because each digit is at most 9.
- Timeout:
  - The idle counter is cleared on every capture.
  - When it reaches TIMEOUT: valid goes to 0, the FSM goes to IDLE, and the match counter clears.
  - ten, one and value hold their last committed values.
- Reset: every output is 0, the FSM is in IDLE, and all counters are 0. Reset asserted mid-frame discards any partial frame.

## Timing
- Capture occurs 2 (synchronizer) + SETTLE_CYCLES cycles after the bus becomes stable.
- Commit: ten, one, value, valid and update all register in the cycle after the completing capture, so update is aligned with the new value.
- err is asserted in the cycle after the failing capture.
- A capture and a timeout in the same cycle: the capture wins and the timeout counter clears.
- A glitch shorter than SETTLE_CYCLES is ignored completely.

## Structure
- Package seg_pkg holds:
  - the ten segment pattern constants SEG_D0..SEG_D9;
  - SEL_TENS = 2'b10 and SEL_ONES = 2'b01;
  - BCD_ERR = 4'hF;
  - the FSM state enum.
- Sub-module seg7_to_bcd is the combinational 8-bit pattern to 4-bit digit lookup, with dp masking.
- The top level contains the synchronizer, settle counter, FSM, stability logic, timeout and binary conversion.

## Test plan
Bench parameters: SETTLE_CYCLES=4, STABLE_FRAMES=2, TIMEOUT=64.
- Scan "24" with each digit held 20 cycles, for 3 frames. Required: after the 2nd frame completes, ten=2, one=4, value=24, valid=1, and one update pulse. The 3rd frame produces no pulse.
- Steady "24", then switch to "23". Required: a single update pulse at the end of the 2nd "23" frame, after which value=23. The dp bit toggling on any digit has no effect.
- Inject a 3-cycle segment glitch mid-hold. Required: no capture, no err, outputs unchanged.
- Present pattern 00000010 on the ones digit. Required: one err pulse, match counter cleared, the committed value held. Two clean frames afterwards recommit with no missed update.
- Stop scanning (digit_con=00) for 64 cycles. Required: valid falls, value holds. Resuming with "24" requires 2 frames, then update pulses with valid=1.
- Assert rst_n low for a single cycle mid-frame, between the tens and ones captures. Required: all outputs 0 immediately, and the next commit needs 2 full new frames.
